// File: rtl/road_sensor_conditioner_pkg.sv
// Shared road occupancy definitions used by the sensor conditioner and the controller.
// Holds the four legal thermometer levels and the legal-code check.
package road_sensor_conditioner_pkg;

    typedef logic [2:0] road_level_t;

    localparam road_level_t RD_EMPTY = 3'b000;
    localparam road_level_t RD_LESS  = 3'b001;
    localparam road_level_t RD_MORE  = 3'b011;
    localparam road_level_t RD_FULL  = 3'b111;

    // Only contiguous thermometer codes filled from the junction end are legal.
    function automatic logic is_legal(input road_level_t code);
        return (code == RD_EMPTY) || (code == RD_LESS) ||
               (code == RD_MORE)  || (code == RD_FULL);
    endfunction

endpackage

// File: rtl/road_sensor_conditioner_if.sv
// Sensor bundle between the raw road sensors and the level-1 controller.
// The master side drives raw codes; the slave (the conditioner) returns clean levels.
interface road_sensor_conditioner_if;
    import road_sensor_conditioner_pkg::*;

    road_level_t R1;
    road_level_t R2;
    road_level_t R3;
    road_level_t R4;
    road_level_t S1;
    road_level_t S2;
    road_level_t S3;
    road_level_t S4;
    logic [3:0]  fault;
    logic [3:0]  level_change;

    modport master (
        output R1, R2, R3, R4,
        input  S1, S2, S3, S4, fault, level_change
    );

    modport slave (
        input  R1, R2, R3, R4,
        output S1, S2, S3, S4, fault, level_change
    );

endinterface

// File: rtl/road_sensor_filter.sv
// One road's conditioning chain: two-flop synchroniser, debounce counter,
// legal-level commit, persistent-illegal-code fault and change strobe.
module road_sensor_filter
    import road_sensor_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FAULT_CYCLES  = 16,
    parameter int CNT_W         = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [2:0]  raw,
    output logic [2:0]  level,
    output logic        fault,
    output logic        change
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_LAST  = CNT_W'(FAULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_SAT   = CNT_W'(FAULT_CYCLES);

    road_level_t      sync1_q, sync2_q;
    road_level_t      cand_q, cand_d;
    road_level_t      level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             chg_q, chg_d;

    // The idle rule is bypassed while faulted so that a return to the current
    // level still has to debounce fully before the fault is released.
    always_comb begin
        cand_d  = cand_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        chg_d   = 1'b0;
        if ((sync2_q == level_q) && !fault_q) begin
            cnt_d  = '0;
            cand_d = sync2_q;
        end else if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (is_legal(cand_q) && (cnt_q == STABLE_LAST)) begin
            level_d = cand_q;
            cnt_d   = '0;
            fault_d = 1'b0;
            chg_d   = (cand_q != level_q);
        end else if (!is_legal(cand_q) && (cnt_q == FAULT_LAST)) begin
            fault_d = 1'b1;
        end else if (cnt_q >= FAULT_SAT) begin
            cnt_d = FAULT_SAT;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_q <= RD_EMPTY;
            sync2_q <= RD_EMPTY;
            cand_q  <= RD_EMPTY;
            level_q <= RD_EMPTY;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            chg_q   <= chg_d;
        end
    end

    assign level  = level_q;
    assign fault  = fault_q;
    assign change = chg_q;

endmodule

// File: rtl/road_sensor_conditioner.sv
// Four independent road filters turning raw occupancy sensors into the
// stable thermometer levels S1..S4 consumed by the level-1 controller.
module road_sensor_conditioner
    import road_sensor_conditioner_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FAULT_CYCLES  = 16,
    parameter int CNT_W         = 5
) (
    input logic                       clock,
    input logic                       clear,
    road_sensor_conditioner_if.slave  bus
);

    road_level_t rawRoad   [4];
    road_level_t levelRoad [4];
    logic [3:0]  faultRoad;
    logic [3:0]  changeRoad;

    assign rawRoad[0] = bus.R1;
    assign rawRoad[1] = bus.R2;
    assign rawRoad[2] = bus.R3;
    assign rawRoad[3] = bus.R4;

    for (genvar i = 0; i < 4; i++) begin : g_road
        road_sensor_filter #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .FAULT_CYCLES  (FAULT_CYCLES),
            .CNT_W         (CNT_W)
        ) u_filter (
            .clock  (clock),
            .clear  (clear),
            .raw    (rawRoad[i]),
            .level  (levelRoad[i]),
            .fault  (faultRoad[i]),
            .change (changeRoad[i])
        );
    end

    assign bus.S1           = levelRoad[0];
    assign bus.S2           = levelRoad[1];
    assign bus.S3           = levelRoad[2];
    assign bus.S4           = levelRoad[3];
    assign bus.fault        = faultRoad;
    assign bus.level_change = changeRoad;

endmodule
